// File: rtl/fht_loader_pkg.sv
// fht_loader_pkg: shared constants for the FHT input loader.
// Loader FSM encodings, ready-guard length and index-width helpers.
package fht_loader_pkg;

   localparam logic [1:0] LD_IDLE  = 2'd0;
   localparam logic [1:0] LD_LOAD  = 2'd1;
   localparam logic [1:0] LD_START = 2'd2;
   localparam logic [1:0] LD_BUSY  = 2'd3;

   // Cycles after iSTART during which a stale core ready is ignored
   localparam logic [1:0] RDY_GUARD = 2'd2;

   // Frame index width: 4 banks of 2^a_bit words
   function automatic int idx_bits(input int a_bit);
      return a_bit + 2;
   endfunction

   function automatic int bank_size(input int a_bit);
      return 1 << a_bit;
   endfunction

endpackage

// File: rtl/fht_loader_bitrev.sv
// fht_loader_bitrev: combinational bit reversal of a W-bit index.
// Ports: iIDX (W) index in, oIDX (W) reversed index out.
module fht_loader_bitrev #(
   parameter int W = 5
) (
   input  logic [W-1:0] iIDX,
   output logic [W-1:0] oIDX
);

   for (genvar i = 0; i < W; i++) begin : g_rev
      assign oIDX[i] = iIDX[W-1-i];
   end

endmodule

// File: rtl/fht_loader.sv
// fht_loader: streams ADC samples into FHT core bank RAM, then starts it.
// Ports: iCLK, iRESET (sync, low), iEN arm, iVALID/iSAMPLE/oREADY stream,
//   oWE/oADDR_WR/oDATA core load port, oSTART/iRDY core control,
//   oBUSY, oDONE pulse, oFRAME_CNT completed frames.
module fht_loader
   import fht_loader_pkg::*;
#(
   parameter int D_BIT   = 16,
   parameter int ADC_BIT = 12,
   parameter int A_BIT   = 3,
   parameter int BIT_REV = 1
) (
   input  logic               iCLK,
   input  logic               iRESET,
   input  logic               iEN,
   input  logic               iVALID,
   input  logic [ADC_BIT-1:0] iSAMPLE,
   output logic               oREADY,
   output logic [3:0]         oWE,
   output logic [A_BIT-1:0]   oADDR_WR,
   output logic [D_BIT-1:0]   oDATA,
   output logic               oSTART,
   input  logic               iRDY,
   output logic               oBUSY,
   output logic               oDONE,
   output logic [15:0]        oFRAME_CNT
);

   localparam int IW = idx_bits(A_BIT);

   logic [1:0]       r_state;
   logic [IW-1:0]    r_cnt;
   logic [1:0]       r_guard;
   logic [3:0]       r_we;
   logic [A_BIT-1:0] r_addr;
   logic [D_BIT-1:0] r_data;
   logic             r_start;
   logic             r_done;
   logic [15:0]      r_frame_cnt;

   logic             w_acc;
   logic             w_last;
   logic [IW-1:0]    w_rev;
   logic [IW-1:0]    w_idx;
   logic [D_BIT-1:0] w_ext;

   fht_loader_bitrev #(
      .W (IW)
   ) u_bitrev (
      .iIDX (r_cnt),
      .oIDX (w_rev)
   );

   assign w_acc  = (r_state == LD_LOAD) & iVALID;
   assign w_last = (r_cnt == {IW{1'b1}});
   assign w_idx  = (BIT_REV != 0) ? w_rev : r_cnt;
   // Signed cast replicates the MSB; equal widths pass straight through
   assign w_ext  = D_BIT'($signed(iSAMPLE));

   always_ff @(posedge iCLK) begin
      if (!iRESET) begin
         r_state     <= LD_IDLE;
         r_cnt       <= '0;
         r_guard     <= '0;
         r_we        <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_start     <= 1'b0;
         r_done      <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_we    <= '0;
         r_start <= 1'b0;
         r_done  <= 1'b0;

         if (w_acc) begin
            r_we   <= 4'b0001 << w_idx[1:0];
            r_addr <= w_idx[IW-1:2];
            r_data <= w_ext;
            r_cnt  <= r_cnt + 1'b1;
         end

         unique case (r_state)
            LD_IDLE: begin
               if (iEN)
                  r_state <= LD_LOAD;
            end
            LD_LOAD: begin
               // Counter rolls over to 0 on its own at the last accept
               if (w_acc && w_last)
                  r_state <= LD_START;
            end
            LD_START: begin
               r_start <= 1'b1;
               r_guard <= '0;
               r_state <= LD_BUSY;
            end
            LD_BUSY: begin
               if (r_guard != RDY_GUARD) begin
                  r_guard <= r_guard + 1'b1;
               end else if (iRDY) begin
                  r_done      <= 1'b1;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
                  r_state     <= iEN ? LD_LOAD : LD_IDLE;
               end
            end
            default: r_state <= LD_IDLE;
         endcase
      end
   end

   assign oREADY     = (r_state == LD_LOAD);
   assign oBUSY      = (r_state == LD_BUSY);
   assign oWE        = r_we;
   assign oADDR_WR   = r_addr;
   assign oDATA      = r_data;
   assign oSTART     = r_start;
   assign oDONE      = r_done;
   assign oFRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_fht_loader.sv
// tb_fht_loader: random-stream bench for fht_loader, bit-reversed and
// natural-order instances checked against a frame-level reference model.
module tb_fht_loader;

   localparam int N = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        valid;
   logic        rdy;
   logic [11:0] smp;

   logic        ready0, ready1;
   logic [3:0]  we0, we1;
   logic [2:0]  addr0, addr1;
   logic [15:0] data0, data1;
   logic        start0, start1;
   logic        busy0, busy1;
   logic        done0, done1;
   logic [15:0] cnt0, cnt1;

   always #5 clk = ~clk;

   fht_loader #(
      .D_BIT(16), .ADC_BIT(12), .A_BIT(3), .BIT_REV(1)
   ) u_rev (
      .iCLK(clk), .iRESET(rst), .iEN(en), .iVALID(valid),
      .iSAMPLE(smp), .oREADY(ready0), .oWE(we0), .oADDR_WR(addr0),
      .oDATA(data0), .oSTART(start0), .iRDY(rdy), .oBUSY(busy0),
      .oDONE(done0), .oFRAME_CNT(cnt0)
   );

   fht_loader #(
      .D_BIT(16), .ADC_BIT(12), .A_BIT(3), .BIT_REV(0)
   ) u_nat (
      .iCLK(clk), .iRESET(rst), .iEN(en), .iVALID(valid),
      .iSAMPLE(smp), .oREADY(ready1), .oWE(we1), .oADDR_WR(addr1),
      .oDATA(data1), .oSTART(start1), .iRDY(rdy), .oBUSY(busy1),
      .oDONE(done1), .oFRAME_CNT(cnt1)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int P_OFF = 0, P_FILL = 1, P_FLUSH = 2, P_XFORM = 3;

   int          m_phase = P_OFF;
   int          m_k = 0;
   int          m_t = 0;
   int          m_frames = 0;
   logic [3:0]  e_we [2];
   int          e_addr [2];
   logic [15:0] e_data;
   bit          e_start, e_done, e_rst;
   int          hits [N];
   int          nwr;

   function automatic int brev5(input int k);
      int r = 0;
      for (int i = 0; i < 5; i++)
         r = r * 2 + ((k >> i) & 1);
      return r;
   endfunction

   function automatic logic [15:0] sext(input logic [11:0] v);
      int s = int'(v);
      if (s >= 2048) s -= 4096;
      return 16'(s);
   endfunction

   always @(posedge clk) begin
      int r [2];
      int b;
      int bad;
      e_start = 0;
      e_done  = 0;
      e_rst   = 0;
      e_we[0] = 4'd0;
      e_we[1] = 4'd0;
      if (!rst) begin
         m_phase  = P_OFF;
         m_k      = 0;
         m_frames = 0;
         e_rst    = 1;
         nwr      = 0;
         for (int i = 0; i < N; i++) hits[i] = 0;
      end else begin
         case (m_phase)
            P_OFF: if (en) m_phase = P_FILL;
            P_FILL: begin
               if (valid) begin
                  r[0] = brev5(m_k);
                  r[1] = m_k;
                  for (int j = 0; j < 2; j++) begin
                     e_we[j]   = 4'(1 << (r[j] % 4));
                     e_addr[j] = r[j] / 4;
                  end
                  e_data = sext(smp);
                  m_k++;
                  if (m_k == N) begin
                     m_k = 0;
                     m_phase = P_FLUSH;
                  end
               end
            end
            P_FLUSH: begin
               e_start = 1;
               m_t = 0;
               m_phase = P_XFORM;
            end
            default: begin
               if (m_t >= 2 && rdy) begin
                  e_done = 1;
                  m_frames++;
                  m_phase = en ? P_FILL : P_OFF;
               end else begin
                  m_t++;
               end
            end
         endcase
      end

      #1;
      chk("ready_rev", ready0, m_phase == P_FILL);
      chk("ready_nat", ready1, m_phase == P_FILL);
      chk("busy_rev", busy0, m_phase == P_XFORM);
      chk("busy_nat", busy1, m_phase == P_XFORM);
      chk("start_rev", start0, e_start);
      chk("start_nat", start1, e_start);
      chk("done_rev", done0, e_done);
      chk("done_nat", done1, e_done);
      chk("cnt_rev", cnt0, m_frames & 16'hFFFF);
      chk("cnt_nat", cnt1, m_frames & 16'hFFFF);
      chk("we_rev", we0, e_we[0]);
      chk("we_nat", we1, e_we[1]);
      if (e_we[0] != 0) begin
         chk("addr_rev", addr0, e_addr[0]);
         chk("addr_nat", addr1, e_addr[1]);
         chk("data_rev", data0, e_data);
         chk("data_nat", data1, e_data);
      end
      if (e_rst) begin
         chk("rst_addr", {addr1, addr0}, 0);
         chk("rst_data", {data1, data0}, 0);
      end
      if (rst) begin
         b = -1;
         case (we0)
            4'b0001: b = 0;
            4'b0010: b = 1;
            4'b0100: b = 2;
            4'b1000: b = 3;
            default: b = -1;
         endcase
         if (b >= 0) begin
            hits[b * 8 + int'(addr0)]++;
            nwr++;
         end
         if (start0 === 1'b1) begin
            bad = 0;
            for (int i = 0; i < N; i++) if (hits[i] != 1) bad++;
            chk("frame_writes", nwr, N);
            chk("frame_pairs_once", bad, 0);
            nwr = 0;
            for (int i = 0; i < N; i++) hits[i] = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   int acc;

   task automatic send1(input logic [11:0] v);
      valid = 1'b1;
      smp   = v;
      if (ready0) acc++;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic send_until(input int target, input int mode);
      int c = 0;
      while (acc < target && c < 400) begin
         if (mode == 0)      valid = 1'b1;
         else if (mode == 1) valid = (c % 3 != 2);
         else                valid = ($urandom % 4 != 0);
         smp = 12'($urandom);
         if (valid && ready0) acc++;
         c++;
         @(negedge clk);
      end
      chk("accepts", acc, target);
   endtask

   task automatic wait_start();
      for (int i = 0; i < 8 && start0 !== 1'b1; i++) @(negedge clk);
      chk("start_seen", start0, 1);
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; valid = 1'b0; rdy = 1'b0; smp = '0;
      acc = 0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {ready0, we0, start0, busy0, done0}, 0);
      chk("reset_cnt", cnt0, 0);

      // Frame 1: directed head, gapped tail, late core ready
      rst = 1'b1;
      en  = 1'b1;
      @(negedge clk);
      chk("arm_ready", ready0, 1);
      send1(12'h123);
      chk("k0_we", we0, 4'b0001);
      chk("k0_addr", addr0, 0);
      chk("k0_data", data0, 16'h0123);
      en = 1'b0;
      send1(12'h800);
      chk("k1_we", we0, 4'b0001);
      chk("k1_addr", addr0, 4);
      chk("k1_data_neg", data0, 16'hF800);
      send1(12'h7FF);
      chk("k2_addr", addr0, 2);
      chk("k2_data_pos", data0, 16'h07FF);
      send1(12'h001);
      chk("k3_we", we0, 4'b0001);
      chk("k3_addr", addr0, 6);
      send1(12'($urandom));
      chk("k4_addr", addr0, 1);
      send1(12'($urandom));
      chk("k5_addr_rev", addr0, 5);
      chk("k5_we_nat", we1, 4'b0010);
      chk("k5_addr_nat", addr1, 1);
      send_until(N, 1);
      valid = 1'b1;
      chk("last_wr_ready", ready0, 0);
      chk("last_wr_start", start0, 0);
      chk("last_wr_we", we0, 4'b1000);
      chk("last_wr_addr", addr0, 7);
      @(negedge clk);
      chk("start_2cyc", start0, 1);
      chk("start_no_we", we0, 0);
      chk("start_busy", busy0, 1);
      valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("late_rdy_nodone", done0, 0);
      rdy = 1'b1;
      @(negedge clk);
      chk("late_rdy_done", done0, 1);
      chk("late_rdy_cnt", cnt0, 1);
      chk("late_rdy_busy", busy0, 0);
      rdy = 1'b0;
      @(negedge clk);
      chk("idle_after", ready0, 0);

      // Frame 2: aborted by reset after 17 accepts
      acc = 0;
      en  = 1'b1;
      @(negedge clk);
      send_until(17, 0);
      rst   = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      chk("abort_outs", {ready0, we0, start0, busy0, done0}, 0);
      chk("abort_cnt", cnt0, 0);

      // Frame 3: restart from k=0, ready held high
      rst = 1'b1;
      rdy = 1'b1;
      acc = 0;
      @(negedge clk);
      send1(12'h5A5);
      chk("restart_we", we0, 4'b0001);
      chk("restart_addr", addr0, 0);
      chk("restart_data", data0, 16'h05A5);
      send_until(N, 2);
      wait_start();
      @(negedge clk);
      chk("guard_s1", done0, 0);
      @(negedge clk);
      chk("guard_s2", done0, 0);
      @(negedge clk);
      chk("guard_s3_done", done0, 1);
      chk("guard_cnt", cnt0, 1);
      chk("reload_ready", ready0, 1);

      // Frame 4: back-to-back rearm
      acc = 0;
      send_until(N, 2);
      wait_start();
      for (int i = 0; i < 8 && done0 !== 1'b1; i++) @(negedge clk);
      chk("f4_done", done0, 1);
      chk("f4_cnt", cnt0, 2);
      en    = 1'b0;
      rdy   = 1'b0;
      valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
